sram_req_arbiter: RTL and testbench

Shares one downstream like-SRAM port between the CPU's instruction-side and data-side like-SRAM requesters. It sits between `mycpu_top`'s `inst_sram_*` / `data_sram_*` buses and a single memory or bridge port.

- Requests are granted one per cycle with fixed data-over-instruction priority.
- A grant is locked until the downstream accepts the address.
- Each accepted request's source is recorded in an in-order ID FIFO.
- Each returning `data_ok` / `rdata` is steered back to the requester that issued it.

---
 rtl/sram_arb_pkg.sv | 14 +
 rtl/sram_id_fifo.sv | 61 ++++++
 rtl/sram_req_arbiter.sv | 152 +++++++++++++++
 tb/tb_sram_req_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the instruction/data like-SRAM request arbiter:
// requester IDs and the grant-lock FSM encoding.
package sram_arb_pkg;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        LOCK_I,
        LOCK_D
    } grant_state_t;

endpackage

// File: rtl/sram_id_fifo.sv
// In-order FIFO of 1-bit requester IDs for accepted-but-not-returned
// transactions; the head tells the return path where data_ok belongs.
module sram_id_fifo #(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic             din,
    output logic             head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap so non-power-of-2 depths never index past the last entry.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only ever read
    // while count says it holds a pushed value.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Arbitrates inst/data like-SRAM requesters onto one downstream port with
// data priority, address-phase locking and in-order data_ok steering.
module sram_req_arbiter
    import sram_arb_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int CNT_W       = $clog2(OUTSTANDING + 1)
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic        sram_req,
    output logic        sram_wr,
    output logic [1:0]  sram_size,
    output logic [3:0]  sram_wstrb,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic        sram_addr_ok,
    input  logic        sram_data_ok,
    input  logic [31:0] sram_rdata,

    output logic        err_stray_ok
);

    grant_state_t     state;
    grant_state_t     state_next;
    logic             grant_valid;
    logic             grant_src;
    logic             granted_req;
    logic             accept;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_head;
    logic [CNT_W-1:0] unused_fifo_count;

    // NOTE: every signal driven here gets a default first so no path
    // through the case can infer a latch.
    always_comb begin
        grant_valid = 1'b0;
        grant_src   = SRC_DATA;
        case (state)
            IDLE: begin
                if (data_sram_req) begin
                    grant_valid = 1'b1;
                    grant_src   = SRC_DATA;
                end else if (inst_sram_req) begin
                    grant_valid = 1'b1;
                    grant_src   = SRC_INST;
                end
            end
            LOCK_I: begin
                grant_valid = 1'b1;
                grant_src   = SRC_INST;
            end
            LOCK_D: begin
                grant_valid = 1'b1;
                grant_src   = SRC_DATA;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (sram_req && !sram_addr_ok)
                    state_next = (grant_src == SRC_DATA) ? LOCK_D : LOCK_I;
            end
            LOCK_I, LOCK_D: begin
                if (sram_addr_ok) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    assign granted_req = grant_valid &&
                         ((grant_src == SRC_DATA) ? data_sram_req : inst_sram_req);
    assign sram_req    = granted_req && !fifo_full;

    always_comb begin
        if (grant_src == SRC_DATA) begin
            sram_wr    = data_sram_wr;
            sram_size  = data_sram_size;
            sram_wstrb = data_sram_wstrb;
            sram_addr  = data_sram_addr;
            sram_wdata = data_sram_wdata;
        end else begin
            sram_wr    = inst_sram_wr;
            sram_size  = inst_sram_size;
            sram_wstrb = inst_sram_wstrb;
            sram_addr  = inst_sram_addr;
            sram_wdata = inst_sram_wdata;
        end
    end

    // Gated by resetn so no address handshake is reported while held in reset.
    assign accept            = sram_req && sram_addr_ok && resetn;
    assign inst_sram_addr_ok = accept && (grant_src == SRC_INST);
    assign data_sram_addr_ok = accept && (grant_src == SRC_DATA);

    sram_id_fifo #(
        .DEPTH (OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_id_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (accept),
        .pop    (sram_data_ok),
        .din    (grant_src),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (unused_fifo_count)
    );

    assign inst_sram_data_ok = sram_data_ok && !fifo_empty && (fifo_head == SRC_INST);
    assign data_sram_data_ok = sram_data_ok && !fifo_empty && (fifo_head == SRC_DATA);
    assign inst_sram_rdata   = sram_rdata;
    assign data_sram_rdata   = sram_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                          err_stray_ok <= 1'b0;
        else if (sram_data_ok && fifo_empty) err_stray_ok <= 1'b1;
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: single read, contention, lock, full,
// stray-after-reset and a randomised push/pop ordering phase.
module tb_sram_req_arbiter;
    import sram_arb_pkg::*;

    localparam int OUTSTANDING = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        sram_req, sram_wr;
    logic [1:0]  sram_size;
    logic [3:0]  sram_wstrb;
    logic [31:0] sram_addr, sram_wdata;
    logic        sram_addr_ok, sram_data_ok;
    logic [31:0] sram_rdata;
    logic        err_stray_ok;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_req_arbiter #(.OUTSTANDING(OUTSTANDING)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .sram_req          (sram_req),
        .sram_wr           (sram_wr),
        .sram_size         (sram_size),
        .sram_wstrb        (sram_wstrb),
        .sram_addr         (sram_addr),
        .sram_wdata        (sram_wdata),
        .sram_addr_ok      (sram_addr_ok),
        .sram_data_ok      (sram_data_ok),
        .sram_rdata        (sram_rdata),
        .err_stray_ok      (err_stray_ok)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change right after the falling edge; checks run 1 ns later.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd2;
        inst_sram_wstrb = 4'h0; inst_sram_addr = '0; inst_sram_wdata = '0;
        data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd2;
        data_sram_wstrb = 4'h0; data_sram_addr = '0; data_sram_wdata = '0;
        sram_addr_ok = 1'b0; sram_data_ok = 1'b0; sram_rdata = '0;
    endtask

    logic q[$];
    logic exp_req, exp_src;

    initial begin
        resetn = 1'b0;
        idle_inputs();
        #1;
        check("rst_sram_req", sram_req, 0);
        check("rst_err", err_stray_ok, 0);
        check("rst_inst_data_ok", inst_sram_data_ok, 0);
        // sram_req follows inputs in reset, but no addr_ok is reported
        inst_sram_req = 1'b1; sram_addr_ok = 1'b1; sram_data_ok = 1'b1;
        #1;
        check("rst_req_follows", sram_req, 1);
        check("rst_inst_addr_ok", inst_sram_addr_ok, 0);
        check("rst_inst_data_ok2", inst_sram_data_ok, 0);
        check("rst_data_data_ok", data_sram_data_ok, 0);
        cyc(); idle_inputs(); resetn = 1'b1;

        // ---- single read ----
        cyc();
        inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_0000; sram_addr_ok = 1'b1;
        #1;
        check("rd_sram_req", sram_req, 1);
        check("rd_sram_addr", sram_addr, 32'hBFC0_0000);
        check("rd_inst_addr_ok", inst_sram_addr_ok, 1);
        check("rd_data_addr_ok", data_sram_addr_ok, 0);
        cyc(); idle_inputs();
        #1;
        check("rd_c1_inst_data_ok", inst_sram_data_ok, 0);
        cyc(); sram_data_ok = 1'b1; sram_rdata = 32'h3C08_0001;
        #1;
        check("rd_c2_inst_data_ok", inst_sram_data_ok, 1);
        check("rd_c2_inst_rdata", inst_sram_rdata, 32'h3C08_0001);
        check("rd_c2_data_data_ok", data_sram_data_ok, 0);
        cyc(); idle_inputs();

        // ---- contention, then full ----
        inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_0004;
        data_sram_req = 1'b1; data_sram_addr = 32'h0000_1000; data_sram_wr = 1'b1;
        data_sram_wstrb = 4'hF; data_sram_wdata = 32'hDEAD_BEEF; sram_addr_ok = 1'b1;
        #1;
        check("ct_addr_d", sram_addr, 32'h0000_1000);
        check("ct_wr_d", sram_wr, 1);
        check("ct_wdata_d", sram_wdata, 32'hDEAD_BEEF);
        check("ct_data_addr_ok", data_sram_addr_ok, 1);
        check("ct_inst_addr_ok0", inst_sram_addr_ok, 0);
        cyc(); data_sram_req = 1'b0;
        #1;
        check("ct_addr_i", sram_addr, 32'hBFC0_0004);
        check("ct_wr_i", sram_wr, 0);
        check("ct_inst_addr_ok1", inst_sram_addr_ok, 1);
        cyc(); inst_sram_addr = 32'hBFC0_0008;
        #1;
        check("full_sram_req", sram_req, 0);
        check("full_inst_addr_ok", inst_sram_addr_ok, 0);
        check("full_data_addr_ok", data_sram_addr_ok, 0);
        cyc(); sram_data_ok = 1'b1; sram_rdata = 32'h1111_1111;
        #1;
        check("ct_ret1_data", data_sram_data_ok, 1);
        check("ct_ret1_inst", inst_sram_data_ok, 0);
        check("ct_ret1_data_rdata", data_sram_rdata, 32'h1111_1111);
        check("full_pop_no_unblock", sram_req, 0);
        cyc(); sram_rdata = 32'h2222_2222;
        #1;
        check("ct_ret2_inst", inst_sram_data_ok, 1);
        check("ct_ret2_data", data_sram_data_ok, 0);
        check("full_next_fwd", sram_req, 1);
        check("full_next_addr", sram_addr, 32'hBFC0_0008);
        check("full_next_addr_ok", inst_sram_addr_ok, 1);
        cyc(); inst_sram_req = 1'b0; sram_rdata = 32'h3333_3333;
        #1;
        check("pp_ret_inst", inst_sram_data_ok, 1);
        cyc(); idle_inputs();

        // ---- lock ----
        inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_0010;
        #1;
        check("lk_c0_req", sram_req, 1);
        check("lk_c0_addr_ok", inst_sram_addr_ok, 0);
        cyc(); data_sram_req = 1'b1; data_sram_addr = 32'h0000_2000;
        #1;
        check("lk_c1_addr", sram_addr, 32'hBFC0_0010);
        check("lk_c1_data_addr_ok", data_sram_addr_ok, 0);
        cyc();
        #1;
        check("lk_c2_addr", sram_addr, 32'hBFC0_0010);
        cyc(); sram_addr_ok = 1'b1;
        #1;
        check("lk_c3_addr", sram_addr, 32'hBFC0_0010);
        check("lk_c3_inst_addr_ok", inst_sram_addr_ok, 1);
        check("lk_c3_data_addr_ok", data_sram_addr_ok, 0);
        cyc(); inst_sram_req = 1'b0;
        #1;
        check("lk_c4_addr", sram_addr, 32'h0000_2000);
        check("lk_c4_data_addr_ok", data_sram_addr_ok, 1);
        cyc(); data_sram_req = 1'b0; sram_addr_ok = 1'b0; sram_data_ok = 1'b1;
        #1;
        check("lk_ret_inst", inst_sram_data_ok, 1);
        cyc();
        #1;
        check("lk_ret_data", data_sram_data_ok, 1);
        check("lk_ret_inst0", inst_sram_data_ok, 0);
        cyc(); idle_inputs();

        // ---- stray data_ok after reset discards outstanding IDs ----
        data_sram_req = 1'b1; data_sram_addr = 32'h0000_3000; sram_addr_ok = 1'b1;
        #1;
        check("st_acc1", data_sram_addr_ok, 1);
        cyc(); data_sram_addr = 32'h0000_3004;
        #1;
        check("st_acc2", data_sram_addr_ok, 1);
        cyc(); idle_inputs();
        #1; resetn = 1'b0; #1; resetn = 1'b1;
        cyc(); sram_data_ok = 1'b1; sram_rdata = 32'h5555_AAAA;
        #1;
        check("st_inst_data_ok", inst_sram_data_ok, 0);
        check("st_data_data_ok", data_sram_data_ok, 0);
        check("st_err_before", err_stray_ok, 0);
        cyc(); sram_data_ok = 1'b0;
        #1;
        check("st_err_set", err_stray_ok, 1);
        cyc();
        #1;
        check("st_err_sticky", err_stray_ok, 1);

        // ---- random push/pop around count=1, addr_ok tied high ----
        #1; resetn = 1'b0; #1; resetn = 1'b1;
        #1;
        check("rnd_err_cleared", err_stray_ok, 0);
        cyc(); inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_1000; sram_addr_ok = 1'b1;
        #1;
        check("rnd_seed_accept", inst_sram_addr_ok, 1);
        q.push_back(SRC_INST);
        for (int i = 0; i < 100; i++) begin
            cyc();
            inst_sram_req  = 1'($urandom_range(0, 1));
            data_sram_req  = 1'($urandom_range(0, 1));
            inst_sram_addr = $urandom;
            data_sram_addr = $urandom;
            sram_data_ok   = (q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            sram_rdata     = $urandom;
            #1;
            exp_req = (inst_sram_req || data_sram_req) && (q.size() < OUTSTANDING);
            exp_src = data_sram_req ? SRC_DATA : SRC_INST;
            check("rnd_sram_req", sram_req, exp_req);
            check("rnd_inst_addr_ok", inst_sram_addr_ok, exp_req && exp_src == SRC_INST);
            check("rnd_data_addr_ok", data_sram_addr_ok, exp_req && exp_src == SRC_DATA);
            if (exp_req)
                check("rnd_sram_addr", sram_addr,
                      (exp_src == SRC_DATA) ? data_sram_addr : inst_sram_addr);
            check("rnd_inst_data_ok", inst_sram_data_ok,
                  sram_data_ok && q.size() > 0 && q[0] == SRC_INST);
            check("rnd_data_data_ok", data_sram_data_ok,
                  sram_data_ok && q.size() > 0 && q[0] == SRC_DATA);
            check("rnd_rdata", data_sram_rdata, sram_rdata);
            if (sram_data_ok && q.size() > 0) void'(q.pop_front());
            if (exp_req) q.push_back(exp_src);
        end
        cyc(); idle_inputs();
        #1;
        check("rnd_no_stray", err_stray_ok, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
